// File: rtl/mmio_fifo_ctrl.sv
// mmio_fifo_ctrl: MMIO-mapped 64-bit FIFO with status/control registers.
// Register map (word offsets from BASE_ADDR): +0 DATA, +2 STATUS, +4 CTRL, +6 STATS.
// Optional feature: define MMIO_FIFO_STATS_EN to add push/pop statistics
// counters behind STATS; without it STATS reads return zero.
module mmio_fifo_ctrl #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TID_W     = 9,
  parameter logic [15:0] BASE_ADDR = 16'h0030
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mmio_wr_valid,
  input  logic             mmio_rd_valid,
  input  logic [15:0]      mmio_addr,
  input  logic [TID_W-1:0] mmio_tid,
  input  logic [63:0]      mmio_wr_data,
  output logic             rsp_valid,
  output logic [TID_W-1:0] rsp_tid,
  output logic [63:0]      rsp_data
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [63:0]      mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [TID_W-1:0] rsp_tid_q, rsp_tid_d;
  logic [63:0]      rsp_data_q, rsp_data_d;

  logic [15:0] off;
  logic        hit, sel_data, sel_ctrl;
  logic        push, pop, push_ok, pop_ok;
  logic        empty, full, clr, flush;
  logic [7:0]  status_cnt;
  logic [63:0] status_word, stats_word;

  // Address decode: only even offsets 0..6 from the base are mapped.
  always_comb begin
    off      = mmio_addr - BASE_ADDR;
    hit      = (off[15:3] == 13'd0) && !off[0];
    sel_data = hit && (off[2:1] == 2'd0);
    sel_ctrl = hit && (off[2:1] == 2'd2);
  end

  // Push/pop qualification; a pop in the same cycle frees the slot a full push needs.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CW'(DEPTH));
    push       = mmio_wr_valid && sel_data;
    pop        = mmio_rd_valid && sel_data;
    pop_ok     = pop && !empty;
    push_ok    = push && (!full || pop_ok);
    clr        = mmio_wr_valid && sel_ctrl && mmio_wr_data[0];
    flush      = mmio_wr_valid && sel_ctrl && mmio_wr_data[1];
    status_cnt = 8'(count_q);
    status_word = {48'd0, status_cnt, 4'd0, unf_q, ovf_q, full, empty};
  end

`ifdef MMIO_FIFO_STATS_EN
  logic [15:0] push_cnt_q, pop_cnt_q;

  // Statistics counters; a clear coinciding with an increment leaves the count at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      push_cnt_q <= '0;
      pop_cnt_q  <= '0;
    end else begin
      push_cnt_q <= (clr ? 16'd0 : push_cnt_q) + 16'(push_ok);
      pop_cnt_q  <= (clr ? 16'd0 : pop_cnt_q) + 16'(pop_ok);
    end
  end

  assign stats_word = {32'd0, pop_cnt_q, push_cnt_q};
`else
  assign stats_word = 64'd0;
`endif

  // Next-state for pointers, count, sticky flags and the read response.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_d       = clr ? 1'b0 : ovf_q;
    unf_d       = clr ? 1'b0 : unf_q;
    rsp_valid_d = mmio_rd_valid && hit;
    rsp_tid_d   = rsp_tid_q;
    rsp_data_d  = rsp_data_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);

    // Event sets take priority over a same-cycle clear.
    if (push && !push_ok) ovf_d = 1'b1;
    if (pop && !pop_ok)   unf_d = 1'b1;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    if (rsp_valid_d) begin
      rsp_tid_d = mmio_tid;
      case (off[2:1])
        2'd0:    rsp_data_d = pop_ok ? mem_q[rd_ptr_q] : 64'd0;
        2'd1:    rsp_data_d = status_word;
        2'd3:    rsp_data_d = stats_word;
        default: rsp_data_d = 64'd0;
      endcase
    end
  end

  // Control/state registers; requests in a reset cycle are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tid_q   <= rsp_tid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // FIFO storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= mmio_wr_data;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_tid   = rsp_tid_q;
  assign rsp_data  = rsp_data_q;

endmodule
